// File: rtl/regfile_read_stage.sv
// regfile_read_stage
//   Operand-read stage that sits between decode and execute. It holds the
//   architectural register file, which the writeback stage writes. It reads
//   both source operands of the issuing instruction, with same-cycle
//   writeback bypass. A per-register scoreboard stalls issue on RAW/WAW
//   hazards. Operands are handed to execute through a one-entry registered
//   valid/ready stage.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid        decode presents an instruction
//   in_ready        instruction accepted this cycle
//   rs1, rs2        source register indices
//   rd_alloc        destination index of the issuing instruction
//   rd_alloc_en     issuing instruction writes rd_alloc
//   out_valid       operands valid to execute
//   out_ready       execute accepts the operands
//   rs1_data        operand 1
//   rs2_data        operand 2
//   out_rd          destination index carried forward
//   out_rd_en       destination write enable carried forward
//   wb_en           writeback write strobe
//   wb_reg          writeback destination
//   wb_data         writeback data
//   flush           squash the held output entry
//   pending         scoreboard bits (debug / verification)
//
// NREGS must equal 2**REGBITS.
module regfile_read_stage #(
    parameter int REGBITS = 5,
    parameter int LOGSIZE = 64,
    parameter int NREGS   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REGBITS-1:0] rs1,
    input  logic [REGBITS-1:0] rs2,
    input  logic [REGBITS-1:0] rd_alloc,
    input  logic               rd_alloc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LOGSIZE-1:0] rs1_data,
    output logic [LOGSIZE-1:0] rs2_data,
    output logic [REGBITS-1:0] out_rd,
    output logic               out_rd_en,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_reg,
    input  logic [LOGSIZE-1:0] wb_data,
    input  logic               flush,
    output logic [NREGS-1:0]   pending
);

    logic [LOGSIZE-1:0] regs_q [NREGS];
    logic [LOGSIZE-1:0] regs_d [NREGS];
    logic [NREGS-1:0]   pending_q, pending_d;
    logic               out_valid_q, out_valid_d;
    logic [LOGSIZE-1:0] rs1_data_q, rs1_data_d;
    logic [LOGSIZE-1:0] rs2_data_q, rs2_data_d;
    logic [REGBITS-1:0] out_rd_q, out_rd_d;
    logic               out_rd_en_q, out_rd_en_d;

    logic               wb_write;
    logic [NREGS-1:0]   wb_mask;
    logic [NREGS-1:0]   flush_mask;
    logic [NREGS-1:0]   alloc_mask;
    logic [NREGS-1:0]   eff_pend;
    logic [LOGSIZE-1:0] src1_val, src2_val;
    logic               haz_rs1, haz_rs2, haz_waw, hazard;
    logic               in_ready_w;
    logic               accept;

    // x0 is hardwired to zero, so a writeback to it is dropped entirely.
    assign wb_write = wb_en && (wb_reg != '0);
    assign wb_mask  = wb_write ? (NREGS'(1) << wb_reg) : '0;

    // A writeback landing this cycle resolves the hazard on its register.
    assign eff_pend = pending_q & ~wb_mask;

    // Bypass: a source matching the writeback takes the incoming data.
    // rsN != 0 already excludes the (dropped) x0 writeback.
    assign src1_val = (rs1 == '0)                  ? '0      :
                      (wb_en && (wb_reg == rs1))   ? wb_data :
                                                     regs_q[rs1];
    assign src2_val = (rs2 == '0)                  ? '0      :
                      (wb_en && (wb_reg == rs2))   ? wb_data :
                                                     regs_q[rs2];

    assign haz_rs1 = (rs1 != '0) && eff_pend[rs1];
    assign haz_rs2 = (rs2 != '0) && eff_pend[rs2];
    // WAW stall keeps at most one in-flight writer per register, so a
    // single pending bit is enough to track it.
    assign haz_waw = rd_alloc_en && (rd_alloc != '0) && eff_pend[rd_alloc];
    assign hazard  = haz_rs1 || haz_rs2 || haz_waw;

    assign in_ready_w = !rst && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready_w;

    // A squashed entry will never write back, so release its destination.
    assign flush_mask = (flush && out_valid_q && out_rd_en_q && (out_rd_q != '0))
                        ? (NREGS'(1) << out_rd_q) : '0;
    assign alloc_mask = (accept && rd_alloc_en && (rd_alloc != '0))
                        ? (NREGS'(1) << rd_alloc) : '0;

    always_comb begin
        regs_d = regs_q;
        if (wb_write) begin
            regs_d[wb_reg] = wb_data;
        end
    end

    // Allocation is OR-ed in last so it wins over a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~wb_mask & ~flush_mask) | alloc_mask;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        out_rd_d    = out_rd_q;
        out_rd_en_d = out_rd_en_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs1_data_d  = src1_val;
            rs2_data_d  = src2_val;
            out_rd_d    = rd_alloc;
            out_rd_en_d = rd_alloc_en;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            out_rd_q    <= '0;
            out_rd_en_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            out_rd_q    <= out_rd_d;
            out_rd_en_q <= out_rd_en_d;
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign out_rd    = out_rd_q;
    assign out_rd_en = out_rd_en_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Testbench for regfile_read_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the register file,
// scoreboard and output entry.
module tb_regfile_read_stage;

    logic        clk, rst, in_valid, rd_alloc_en, out_ready, wb_en, flush;
    logic [4:0]  rs1, rs2, rd_alloc, wb_reg;
    logic [63:0] wb_data;
    logic        in_ready, out_valid, out_rd_en;
    logic [63:0] rs1_data, rs2_data;
    logic [4:0]  out_rd;
    logic [31:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_read_stage #(.REGBITS(5), .LOGSIZE(64), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd_alloc(rd_alloc), .rd_alloc_en(rd_alloc_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_rd(out_rd), .out_rd_en(out_rd_en),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model
    logic [63:0] m_rf [32];
    logic [31:0] m_pend;
    logic        m_ov, m_rden;
    logic [63:0] m_d1, m_d2;
    logic [4:0]  m_rd;

    function automatic logic m_blocked(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(wb_en && wb_reg == r);
    endfunction

    function automatic logic m_ready();
        return !rst && !flush && !m_blocked(rs1) && !m_blocked(rs2) &&
               !(rd_alloc_en && m_blocked(rd_alloc)) && (!m_ov || out_ready);
    endfunction

    task automatic m_tick();
        logic acc;
        acc = in_valid && m_ready();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
            m_pend = 0; m_ov = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_rden = 0;
        end else begin
            // Writeback first: a read in the same cycle then sees the new value.
            if (wb_en && wb_reg != 0) begin
                m_rf[wb_reg] = wb_data;
                m_pend[wb_reg] = 1'b0;
            end
            if (flush) begin
                if (m_ov && m_rden && m_rd != 0) m_pend[m_rd] = 1'b0;
                m_ov = 1'b0;
            end else if (acc) begin
                m_ov   = 1'b1;
                m_d1   = (rs1 == 0) ? 64'd0 : m_rf[rs1];
                m_d2   = (rs2 == 0) ? 64'd0 : m_rf[rs2];
                m_rd   = rd_alloc;
                m_rden = rd_alloc_en;
                if (rd_alloc_en && rd_alloc != 0) m_pend[rd_alloc] = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_tick();
        #1;
    endtask

    task automatic idle();
        in_valid = 0; rs1 = 0; rs2 = 0; rd_alloc = 0; rd_alloc_en = 0;
        out_ready = 1; wb_en = 0; wb_reg = 0; wb_data = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle();
        wb_en = 1; wb_reg = 5; wb_data = 64'h55;
        in_valid = 1; rd_alloc = 4; rd_alloc_en = 1;
        cyc();
        idle(); out_ready = 0;
        cyc();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %0b want 1", out_valid); end
        n_tests++; if (pending[4] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pend4 got %0b want 1", pending[4]); end
        rst = 1; in_valid = 1; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        cyc();
        rst = 0; idle();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending); end
        n_tests++; if ({out_rd, out_rd_en} !== 6'd0) begin n_fail++; $display("FAIL reset_out_rd got %h/%0b want 0/0", out_rd, out_rd_en); end
        n_tests++; if ({rs1_data, rs2_data} !== 128'd0) begin n_fail++; $display("FAIL reset_data got %h %h want 0 0", rs1_data, rs2_data); end
        in_valid = 1; rs1 = 5; rs2 = 0; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_in_ready got %0b want 1", in_ready); end
        cyc();
        idle();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_out_valid got %0b want 1", out_valid); end
        n_tests++; if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin n_fail++; $display("FAIL first_data got %h %h want 0 0", rs1_data, rs2_data); end
        n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL first_pending got %h want 0", pending); end
    endtask

    task automatic test_bypass();
        idle();
        in_valid = 1; rs1 = 5;
        wb_en = 1; wb_reg = 5; wb_data = 64'hDEAD;
        cyc();
        n_tests++; if (rs1_data !== 64'hDEAD) begin n_fail++; $display("FAIL bypass_rs1 got %h want dead", rs1_data); end
        wb_en = 0; wb_data = 0; rs2 = 5;
        cyc();
        idle();
        n_tests++; if (rs1_data !== 64'hDEAD || rs2_data !== 64'hDEAD) begin n_fail++; $display("FAIL array_read got %h %h want dead dead", rs1_data, rs2_data); end
    endtask

    task automatic test_raw_stall();
        idle();
        in_valid = 1; rd_alloc = 3; rd_alloc_en = 1;
        cyc();
        n_tests++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL raw_alloc_pend3 got %0b want 1", pending[3]); end
        rd_alloc = 0; rd_alloc_en = 0; rs2 = 3;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d got in_ready %0b want 0", i, in_ready); end
            cyc();
        end
        wb_en = 1; wb_reg = 3; wb_data = 64'h1234; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got in_ready %0b want 1", in_ready); end
        cyc();
        idle();
        n_tests++; if (out_valid !== 1'b1 || rs2_data !== 64'h1234) begin n_fail++; $display("FAIL raw_bypass got %0b/%h want 1/1234", out_valid, rs2_data); end
        n_tests++; if (pending[3] !== 1'b0) begin n_fail++; $display("FAIL raw_clear_pend3 got %0b want 0", pending[3]); end
    endtask

    task automatic test_x0();
        idle();
        wb_en = 1; wb_reg = 0; wb_data = 64'hFFFF;
        in_valid = 1; rd_alloc = 0; rd_alloc_en = 1;
        cyc();
        n_tests++; if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin n_fail++; $display("FAIL x0_bypass got %h %h want 0 0", rs1_data, rs2_data); end
        n_tests++; if (pending !== 32'd0 || out_rd_en !== 1'b1) begin n_fail++; $display("FAIL x0_alloc got pend %h en %0b want 0/1", pending, out_rd_en); end
        wb_en = 0; wb_data = 0; rd_alloc_en = 0;
        cyc();
        idle();
        n_tests++; if (rs1_data !== 64'd0) begin n_fail++; $display("FAIL x0_array got %h want 0", rs1_data); end
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1; rs1 = 5; rd_alloc = 9;
        cyc();
        out_ready = 0; rs1 = 0; rs2 = 5; rd_alloc = 10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got %0b want 0", i, in_ready); end
            cyc();
            n_tests++; if (out_valid !== 1'b1 || rs1_data !== 64'hDEAD || out_rd !== 5'd9) begin n_fail++; $display("FAIL bp_hold_%0d got %0b/%h/%0d want 1/dead/9", i, out_valid, rs1_data, out_rd); end
        end
        out_ready = 1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0b want 1", in_ready); end
        cyc();
        n_tests++; if (out_rd !== 5'd10 || rs2_data !== 64'hDEAD || rs1_data !== 64'd0) begin n_fail++; $display("FAIL bp_next got %0d/%h/%h want 10/dead/0", out_rd, rs2_data, rs1_data); end
        for (int i = 0; i < 3; i++) begin
            rd_alloc = 5'(11 + i); #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %0b want 1", i, in_ready); end
            cyc();
            n_tests++; if (out_valid !== 1'b1 || out_rd !== 5'(11 + i)) begin n_fail++; $display("FAIL b2b_out_%0d got %0b/%0d want 1/%0d", i, out_valid, out_rd, 11 + i); end
        end
        idle();
        cyc();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1; rd_alloc = 7; rd_alloc_en = 1;
        cyc();
        n_tests++; if (pending[7] !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_alloc got %0b/%0b want 1/1", pending[7], out_valid); end
        rd_alloc_en = 0; rd_alloc = 0; rs1 = 7; out_ready = 0; flush = 1; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready got %0b want 0", in_ready); end
        cyc();
        n_tests++; if (out_valid !== 1'b0 || pending[7] !== 1'b0) begin n_fail++; $display("FAIL fl_squash got %0b/%0b want 0/0", out_valid, pending[7]); end
        flush = 0; out_ready = 1; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_no_stall got %0b want 1", in_ready); end
        cyc();
        n_tests++; if (out_valid !== 1'b1 || rs1_data !== 64'd0) begin n_fail++; $display("FAIL fl_reissue got %0b/%h want 1/0", out_valid, rs1_data); end
        rs1 = 0; rd_alloc = 8; rd_alloc_en = 1;
        cyc();
        idle();
        cyc();
        flush = 1;
        cyc();
        flush = 0;
        n_tests++; if (out_valid !== 1'b0 || pending[8] !== 1'b1) begin n_fail++; $display("FAIL fl_empty got %0b/%0b want 0/1", out_valid, pending[8]); end
        in_valid = 1; rd_alloc = 8; rd_alloc_en = 1; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall got %0b want 0", in_ready); end
        wb_en = 1; wb_reg = 8; wb_data = 64'h88; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release got %0b want 1", in_ready); end
        cyc();
        n_tests++; if (pending[8] !== 1'b1) begin n_fail++; $display("FAIL set_wins got %0b want 1", pending[8]); end
        in_valid = 0; rd_alloc_en = 0;
        cyc();
        idle();
        n_tests++; if (pending !== 32'd0) begin n_fail++; $display("FAIL wb_clear got %h want 0", pending); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            rd_alloc    = 5'($urandom_range(0, 7));
            rd_alloc_en = $urandom_range(0, 1) == 1;
            out_ready   = ($urandom_range(0, 9) < 7);
            wb_en       = $urandom_range(0, 1) == 1;
            wb_reg      = 5'($urandom_range(0, 7));
            wb_data     = {$urandom, $urandom};
            flush       = ($urandom_range(0, 15) == 0);
            #1;
            n_tests++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got %0b want %0b", c, in_ready, m_ready()); end
            cyc();
            n_tests++; if (out_valid !== m_ov || pending !== m_pend) begin n_fail++; $display("FAIL rnd_state c=%0d got %0b/%h want %0b/%h", c, out_valid, pending, m_ov, m_pend); end
            n_tests++; if (rs1_data !== m_d1 || rs2_data !== m_d2 || out_rd !== m_rd || out_rd_en !== m_rden) begin
                n_fail++; $display("FAIL rnd_entry c=%0d got %h %h %0d %0b want %h %h %0d %0b", c, rs1_data, rs2_data, out_rd, out_rd_en, m_d1, m_d2, m_rd, m_rden);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        test_reset();
        test_bypass();
        test_raw_stall();
        test_x0();
        test_backpressure();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
